ahb_sram_subordinate: RTL and testbench
=======================================

Name: ahb_sram_subordinate

Overview:
Synthesizable AHB subordinate that fronts an on-chip SRAM array. It is the responder end of the bus that ahb_manager initiates on, and it replaces the behavioural subordinate model in system builds and benches. It decodes address-phase controls, inserts programmable wait states, and performs byte-lane writes and full-word reads. Illegal accesses get the two-cycle ERROR response.

Parameters:
DATA_WDT, 32, data bus width in bits (32 or 64).
MEM_DEPTH, 256, number of DATA_WDT-bit words in the array.
BASE_ADDR, 0, byte address mapped to word 0. Must be aligned to DATA_WDT/8.
WAIT_STATES, 0, number of o_hreadyout=0 cycles inserted per OKAY transfer (0..15).

Ports:
i_hclk  in  1  bus clock; all logic on rising edge.
i_hreset_n  in  1  asynchronous active-low reset.
i_hsel  in  1  subordinate select (address phase).
i_haddr  in  32  byte address.
i_htrans  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
i_hwrite  in  1  1=write.
i_hsize  in  3  W8=0 .. W1024=7.
i_hburst  in  3  burst type; informational only, no address prediction.
i_hwdata  in  DATA_WDT  write data (data phase).
i_hready  in  1  bus-level HREADY; address phase is sampled only when high.
o_hrdata  out  DATA_WDT  read data; valid when o_hreadyout=1 in a read data phase.
o_hreadyout  out  1  transfer-done indication to the bus.
o_hresp  out  2  OKAY=0, ERROR=1. SPLIT/RETRY are never issued.
o_err_cnt  out  16  saturating count of ERROR responses issued.

Behaviour:
- Reset (async assert, sync release): o_hreadyout=1, o_hresp=OKAY, o_hrdata=0, o_err_cnt=0, FSM=IDLE, no pending write. SRAM contents are not reset.
- Accept: i_hsel & i_hready & i_htrans[1]. On accept, register addr, write, size and an error flag.
- Error flag is set when any of the following holds:
  - word index = (i_haddr-BASE_ADDR)>>log2(DATA_WDT/8) is >= MEM_DEPTH, or i_haddr < BASE_ADDR;
  - i_hsize > log2(DATA_WDT/8);
  - i_haddr is not aligned to 2^i_hsize.
- IDLE/BUSY accepted, or not selected: next data phase is zero-wait OKAY, no memory access.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
  - IDLE: on a legal accept, go to WAIT if WAIT_STATES>0, else DATA. On an illegal accept, go to ERR1.
  - WAIT: o_hreadyout=0, o_hresp=OKAY. A counter is loaded with WAIT_STATES-1; go to DATA when it reaches 0.
  - DATA: o_hreadyout=1, o_hresp=OKAY, transfer completes. A new accept in the same cycle follows the IDLE rules (back-to-back pipelining). Otherwise return to IDLE.
  - ERR1: o_hreadyout=0, o_hresp=ERROR; always go to ERR2.
  - ERR2: o_hreadyout=1, o_hresp=ERROR; o_err_cnt increments unless it equals 0xFFFF. A new accept in ERR2 is honoured, because the manager may issue IDLE here to cancel a burst.
- Write:
  - i_hwdata is sampled in the DATA cycle.
  - Byte lanes enabled = 2^size bytes starting at haddr[log2(DATA_WDT/8)-1:0], little-endian; other bytes are unchanged.
  - The array is written at the end of DATA (single-cycle write port).
- Read:
  - Array read is issued at accept, or at the end of WAIT.
  - o_hrdata is driven with the full word, registered, and valid in DATA. It holds its last value otherwise.
- Hazard: a read accepted in the DATA cycle of a write to the same word returns the merged new word (bypass). Zero extra wait.
- Errored transfers never modify the array. o_hrdata is unchanged on an errored read.
- o_hresp=ERROR with o_hreadyout=1 only ever follows an ERR1 cycle.
- Reset asserted mid-transfer: outputs return to reset values immediately. A pending write is dropped.

Test Plan:
- Reset: hold i_hreset_n=0 for 3 cycles, then release -> o_hreadyout=1, o_hresp=0, o_err_cnt=0 throughout.
- WAIT_STATES=0, DATA_WDT=32, BASE_ADDR=0x400:
  - Write 0xDEADBEEF to 0x404 (W32), then read 0x404 -> read data phase has o_hreadyout=1 in its first cycle and o_hrdata=0xDEADBEEF.
  - Back-to-back: write 0x11223344 to 0x408 with a read of 0x408 in the next address phase -> o_hrdata=0x11223344 (bypass), no wait.
- Byte lanes: preload 0x408=0x00000000, write W8 0xAA on lane 1 at 0x409, then read 0x408 -> 0x0000AA00. W16 write at 0x40B -> ERROR (misaligned).
- Out-of-range: read 0x400+4*MEM_DEPTH -> ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), o_err_cnt=1, array untouched. Manager drives IDLE in ERR2 -> next phase OKAY.
- WAIT_STATES=3, INCR4 read burst of 0x400..0x40C -> each beat shows exactly 3 cycles of o_hreadyout=0, then 1. i_hready=0 from another subordinate suppresses the accept.

Source files
------------

// File: rtl/ahb_sram_subordinate_if.sv
// ----------------------------------------------------------------------------
// ahb_sram_subordinate_if
// AHB bus bundle between a manager and the SRAM subordinate.
//   master modport : drives address/control/write data, observes responses
//   slave  modport : observes address/control/write data, drives responses
// Signals: i_hsel, i_haddr[31:0], i_htrans[1:0], i_hwrite, i_hsize[2:0],
//          i_hburst[2:0], i_hwdata[DATA_WDT-1:0], i_hready,
//          o_hrdata[DATA_WDT-1:0], o_hreadyout, o_hresp[1:0]
// ----------------------------------------------------------------------------
interface ahb_sram_subordinate_if #(
    parameter int DATA_WDT = 32
);
    logic                i_hsel;
    logic [31:0]         i_haddr;
    logic [1:0]          i_htrans;
    logic                i_hwrite;
    logic [2:0]          i_hsize;
    logic [2:0]          i_hburst;
    logic [DATA_WDT-1:0] i_hwdata;
    logic                i_hready;
    logic [DATA_WDT-1:0] o_hrdata;
    logic                o_hreadyout;
    logic [1:0]          o_hresp;

    modport master (
        output i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
               i_hwdata, i_hready,
        input  o_hrdata, o_hreadyout, o_hresp
    );

    modport slave (
        input  i_hsel, i_haddr, i_htrans, i_hwrite, i_hsize, i_hburst,
               i_hwdata, i_hready,
        output o_hrdata, o_hreadyout, o_hresp
    );
endinterface

// File: rtl/ahb_sram_subordinate.sv
// ----------------------------------------------------------------------------
// ahb_sram_subordinate
// AHB subordinate in front of an on-chip SRAM. Decodes the address phase,
// inserts WAIT_STATES wait cycles per OKAY transfer, writes byte lanes,
// returns full words on reads and answers illegal accesses with the
// two-cycle ERROR response.
// Ports:
//   i_hclk      bus clock, rising edge
//   i_hreset_n  asynchronous active-low reset
//   bus         AHB signals (slave modport of ahb_sram_subordinate_if)
//   o_err_cnt   saturating count of ERROR responses issued
// ----------------------------------------------------------------------------
module ahb_sram_subordinate #(
    parameter int          DATA_WDT    = 32,
    parameter int          MEM_DEPTH   = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_STATES = 0
) (
    input  logic                       i_hclk,
    input  logic                       i_hreset_n,
    ahb_sram_subordinate_if.slave      bus,
    output logic [15:0]                o_err_cnt
);
    localparam int NB = DATA_WDT / 8;
    localparam int LB = $clog2(NB);
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY  = 2'd0;
    localparam logic [1:0] RESP_ERROR = 2'd1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t              state;
    logic [DATA_WDT-1:0] mem [MEM_DEPTH];

    // data-phase copy of the accepted address phase
    logic [AW-1:0]       d_idx;
    logic [LB-1:0]       d_lane;
    logic [2:0]          d_size;
    logic                d_write;
    logic [3:0]          wcnt;

    logic [DATA_WDT-1:0] hrdata_q;
    logic                hreadyout_q;
    logic [1:0]          hresp_q;
    logic [15:0]         err_cnt_q;

    // ---------------- address-phase decode ----------------
    logic        acc;
    logic        can_acc;
    logic [31:0] off;
    logic [31:0] widx;
    logic        a_err;
    logic [AW-1:0] a_idx;

    assign can_acc = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
    assign acc     = can_acc & bus.i_hsel & bus.i_hready & bus.i_htrans[1];
    assign off     = bus.i_haddr - BASE_ADDR;
    assign widx    = off >> LB;
    assign a_idx   = widx[AW-1:0];
    // below base wraps off to a huge value, but is tested explicitly for clarity
    assign a_err   = (bus.i_haddr < BASE_ADDR)
                  || (widx >= 32'(MEM_DEPTH))
                  || (bus.i_hsize > 3'(LB))
                  || ((bus.i_haddr & ((32'd1 << bus.i_hsize) - 32'd1)) != 32'd0);

    // ---------------- write path ----------------
    logic                wr_en;
    logic [NB-1:0]       be;
    logic [DATA_WDT-1:0] wr_word;

    assign wr_en = (state == S_DATA) && d_write;

    always_comb begin
        be      = '0;
        wr_word = mem[d_idx];
        for (int b = 0; b < NB; b++) begin
            if (b >= int'(d_lane) && b < int'(d_lane) + (1 << d_size))
                be[b] = 1'b1;
            if (be[b])
                wr_word[8*b +: 8] = bus.i_hwdata[8*b +: 8];
        end
    end

    always_ff @(posedge i_hclk) begin
        if (wr_en)
            mem[d_idx] <= wr_word;
    end

    // ---------------- read path ----------------
    // A read enters DATA either straight from an accept or at the end of WAIT.
    // When the accept lands in the DATA cycle of a write to the same word, the
    // merged word is forwarded because the array is only updated at this edge.
    logic [AW-1:0]       rd_idx;
    logic [DATA_WDT-1:0] rd_word;

    assign rd_idx  = (state == S_WAIT) ? d_idx : a_idx;
    assign rd_word = (wr_en && d_idx == rd_idx) ? wr_word : mem[rd_idx];

    // ---------------- control FSM ----------------
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= RESP_OKAY;
            hrdata_q    <= '0;
            err_cnt_q   <= '0;
            d_idx       <= '0;
            d_lane      <= '0;
            d_size      <= '0;
            d_write     <= 1'b0;
            wcnt        <= '0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (wcnt == 4'd0) begin
                        state       <= S_DATA;
                        hreadyout_q <= 1'b1;
                        if (!d_write)
                            hrdata_q <= rd_word;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    // counter is bumped entering ERR2 so it already reads the
                    // new total while the error completes on the bus
                    state       <= S_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= RESP_ERROR;
                    if (err_cnt_q != 16'hFFFF)
                        err_cnt_q <= err_cnt_q + 16'd1;
                end
                default: begin // S_IDLE, S_DATA, S_ERR2 may take a new transfer
                    if (acc) begin
                        d_idx   <= a_idx;
                        d_lane  <= bus.i_haddr[LB-1:0];
                        d_size  <= bus.i_hsize;
                        d_write <= bus.i_hwrite;
                        if (a_err) begin
                            state       <= S_ERR1;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RESP_ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state       <= S_WAIT;
                            hreadyout_q <= 1'b0;
                            hresp_q     <= RESP_OKAY;
                            wcnt        <= 4'(WAIT_STATES - 1);
                        end else begin
                            state       <= S_DATA;
                            hreadyout_q <= 1'b1;
                            hresp_q     <= RESP_OKAY;
                            if (!bus.i_hwrite)
                                hrdata_q <= rd_word;
                        end
                    end else begin
                        state       <= S_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= RESP_OKAY;
                    end
                end
            endcase
        end
    end

    assign bus.o_hrdata    = hrdata_q;
    assign bus.o_hreadyout = hreadyout_q;
    assign bus.o_hresp     = hresp_q;
    assign o_err_cnt       = err_cnt_q;
endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// ----------------------------------------------------------------------------
// tb_ahb_sram_subordinate
// Two subordinates (0 and 3 wait states) share one driven address bus; only
// the selected one sees i_hsel. A byte-addressed reference memory predicts
// every response, which is queued at accept time and checked by a monitor
// at each data-phase completion.
// ----------------------------------------------------------------------------
module tb_ahb_sram_subordinate;
    localparam int          DW    = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h400;

    typedef struct packed {
        logic        err;
        logic        wr;
        logic [31:0] data;
        logic [15:0] ecnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared manager-side drive
    logic        b_hsel = 1'b0;
    logic [31:0] b_addr = '0;
    logic [1:0]  b_trans = 2'd0;
    logic        b_write = 1'b0;
    logic [2:0]  b_size = 3'd0;
    logic [2:0]  b_burst = 3'd0;
    logic [31:0] b_wdata = '0;
    logic        ext_rdy = 1'b1;
    int          sel = 0;

    ahb_sram_subordinate_if #(.DATA_WDT(DW)) if0 ();
    ahb_sram_subordinate_if #(.DATA_WDT(DW)) if1 ();
    logic [15:0] ecnt0, ecnt1;

    assign if0.i_hsel   = b_hsel && (sel == 0);
    assign if1.i_hsel   = b_hsel && (sel == 1);
    assign if0.i_haddr  = b_addr;   assign if1.i_haddr  = b_addr;
    assign if0.i_htrans = b_trans;  assign if1.i_htrans = b_trans;
    assign if0.i_hwrite = b_write;  assign if1.i_hwrite = b_write;
    assign if0.i_hsize  = b_size;   assign if1.i_hsize  = b_size;
    assign if0.i_hburst = b_burst;  assign if1.i_hburst = b_burst;
    assign if0.i_hwdata = b_wdata;  assign if1.i_hwdata = b_wdata;
    assign if0.i_hready = if0.o_hreadyout & ext_rdy;
    assign if1.i_hready = if1.o_hreadyout & ext_rdy;

    ahb_sram_subordinate #(.DATA_WDT(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
                           .WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset_n(rst_n), .bus(if0), .o_err_cnt(ecnt0));
    ahb_sram_subordinate #(.DATA_WDT(DW), .MEM_DEPTH(DEPTH), .BASE_ADDR(BASE),
                           .WAIT_STATES(3)) u_dut1 (
        .i_hclk(clk), .i_hreset_n(rst_n), .bus(if1), .o_err_cnt(ecnt1));

    logic        rdy [2];
    logic [1:0]  rsp [2];
    logic [31:0] rdat [2];
    logic [15:0] ecnt [2];
    logic        hs [2];
    logic        hr [2];
    assign rdy[0] = if0.o_hreadyout; assign rdy[1] = if1.o_hreadyout;
    assign rsp[0] = if0.o_hresp;     assign rsp[1] = if1.o_hresp;
    assign rdat[0] = if0.o_hrdata;   assign rdat[1] = if1.o_hrdata;
    assign ecnt[0] = ecnt0;          assign ecnt[1] = ecnt1;
    assign hs[0] = if0.i_hsel;       assign hs[1] = if1.i_hsel;
    assign hr[0] = if0.i_hready;     assign hr[1] = if1.i_hready;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", nm, k, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] mb [2][4*DEPTH];
    int         ecnt_m [2];
    exp_t       q0 [$];
    exp_t       q1 [$];

    task automatic model(input int k, input logic [31:0] a, input logic w,
                         input logic [2:0] sz, input logic [31:0] d);
        exp_t e;
        int   nby;
        logic legal;
        nby   = 1 << sz;
        legal = (a >= BASE) && ((a - BASE) < 32'(4*DEPTH)) && (sz <= 3'd2)
                && ((a % 32'(nby)) == 32'd0);
        e.err = !legal;
        e.wr  = w;
        e.data = '0;
        if (legal && w) begin
            for (int b = 0; b < nby; b++) begin
                int unsigned ab;
                ab = a + 32'(b);
                mb[k][ab - BASE] = d[8*(ab % 4) +: 8];
            end
        end else if (legal) begin
            int unsigned wa;
            wa = (a - BASE) & ~32'd3;
            e.data = {mb[k][wa+3], mb[k][wa+2], mb[k][wa+1], mb[k][wa]};
        end
        if (!legal && ecnt_m[k] < 16'hFFFF) ecnt_m[k]++;
        e.ecnt = 16'(ecnt_m[k]);
        if (k == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] d, input logic [2:0] burst,
                         input logic seq, input int stall);
        int n;
        b_hsel  = 1'b1;
        b_addr  = a;
        b_write = w;
        b_size  = sz;
        b_burst = burst;
        b_trans = seq ? 2'd3 : 2'd2;
        if (stall > 0) begin
            ext_rdy = 1'b0;
            repeat (stall) @(posedge clk);
            #1 ext_rdy = 1'b1;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!hr[sel] && n < 100);
        if (n >= 100) chk("accept_timeout", sel, 32'(n), 32'd0);
        @(posedge clk);
        model(sel, a, w, sz, d);
        #1;
        b_trans = 2'd0;
        b_wdata = w ? d : $urandom;
    endtask

    task automatic idle(input int n);
        b_trans = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'd0;  // BUSY or IDLE
        b_hsel  = $urandom_range(0, 1) == 1;
        repeat (n) @(posedge clk);
        #1 b_trans = 2'd0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic        mon_en = 1'b0;
    logic        act [2] = '{1'b0, 1'b0};
    int          nw [2];
    int          ner [2];
    logic [31:0] last_rd [2] = '{32'd0, 32'd0};

    always @(negedge clk) begin
        if (mon_en) begin
            for (int k = 0; k < 2; k++) begin
                if (act[k]) begin
                    if (!rdy[k]) begin
                        nw[k]++;
                        if (rsp[k] == 2'd1) ner[k]++;
                    end else begin
                        exp_t e;
                        int   qs;
                        qs = (k == 0) ? q0.size() : q1.size();
                        chk("sb_nonempty", k, 32'(qs > 0), 32'd1);
                        if (qs > 0) begin
                            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                            if (e.err) begin
                                chk("err1_cycles", k, 32'(nw[k]), 32'd1);
                                chk("err1_resp", k, 32'(ner[k]), 32'd1);
                                chk("err2_resp", k, 32'(rsp[k]), 32'd1);
                                chk("err_cnt", k, 32'(ecnt[k]), 32'(e.ecnt));
                                if (!e.wr) chk("err_rdata_hold", k, rdat[k], last_rd[k]);
                            end else begin
                                chk("wait_cycles", k, 32'(nw[k]), (k == 0) ? 32'd0 : 32'd3);
                                chk("okay_resp", k, 32'(rsp[k] | 2'(ner[k] != 0)), 32'd0);
                                if (!e.wr) begin
                                    chk("rdata", k, rdat[k], e.data);
                                    last_rd[k] = e.data;
                                end
                            end
                        end
                        act[k] = 1'b0;
                    end
                end else begin
                    chk("idle_okay", k, {29'd0, rdy[k], rsp[k]}, 32'd4);
                end
                if (hs[k] && hr[k] && b_trans[1]) begin
                    act[k] = 1'b1;
                    nw[k]  = 0;
                    ner[k] = 0;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        ecnt_m[0] = 0;
        ecnt_m[1] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("rst_hreadyout", k, 32'(rdy[k]), 32'd1);
            chk("rst_hresp", k, 32'(rsp[k]), 32'd0);
            chk("rst_err_cnt", k, 32'(ecnt[k]), 32'd0);
            chk("rst_hrdata", k, rdat[k], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // fill both arrays so every read has a defined expectation
        for (int k = 0; k < 2; k++) begin
            sel = k;
            for (int i = 0; i < DEPTH; i++)
                issue(BASE + 32'(4*i), 1'b1, 3'd2, $urandom, 3'd1, 1'b0, 0);
            idle(2);
        end

        // zero-wait directed cases
        sel = 0;
        issue(32'h404, 1'b1, 3'd2, 32'hDEADBEEF, 3'd0, 1'b0, 0);
        idle(1);
        issue(32'h404, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0);
        issue(32'h408, 1'b1, 3'd2, 32'h11223344, 3'd0, 1'b0, 0);
        issue(32'h408, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0);           // bypass
        issue(32'h408, 1'b1, 3'd2, 32'h00000000, 3'd0, 1'b0, 0);
        issue(32'h409, 1'b1, 3'd0, 32'h0000AA00, 3'd0, 1'b0, 0);    // lane 1
        issue(32'h408, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0);
        issue(32'h40B, 1'b1, 3'd1, 32'hFFFFFFFF, 3'd0, 1'b0, 0);    // misaligned
        issue(BASE + 32'(4*DEPTH), 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0); // out of range
        idle(2);
        issue(32'h3FC, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0);           // below base
        issue(32'h400, 1'b0, 3'd3, 32'h0, 3'd0, 1'b0, 0);           // too wide
        issue(32'h408, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 0);           // untouched
        idle(2);

        // three-wait directed cases: INCR4 burst, then a stalled accept
        sel = 1;
        for (int i = 0; i < 4; i++)
            issue(32'h400 + 32'(4*i), 1'b0, 3'd2, 32'h0, 3'd3, i != 0, 0);
        idle(3);
        issue(32'h40C, 1'b0, 3'd2, 32'h0, 3'd0, 1'b0, 3);
        idle(2);

        // randomized traffic on both subordinates
        for (int k = 0; k < 2; k++) begin
            sel = k;
            for (int i = 0; i < 150; i++) begin
                logic [31:0] a;
                logic [2:0]  sz;
                sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1)
                    a = BASE + 32'($urandom_range(0, 15));              // hazard-prone
                else
                    a = BASE - 32'd8 + 32'($urandom_range(0, 4*DEPTH + 16));
                if ($urandom_range(0, 9) < 7)
                    a = a & ~((32'd1 << sz) - 32'd1);
                issue(a, $urandom_range(0, 1) == 1, sz, $urandom, 3'd1, 1'b0, 0);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            idle(2);
        end

        idle(10);
        chk("sb_drain0", 0, 32'(q0.size()), 32'd0);
        chk("sb_drain1", 1, 32'(q1.size()), 32'd0);
        chk("err_cnt_final0", 0, 32'(ecnt[0]), 32'(ecnt_m[0]));
        chk("err_cnt_final1", 1, 32'(ecnt[1]), 32'(ecnt_m[1]));
        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end
endmodule
